// File: rtl/b03_tracker_pkg.sv
// Shared types and helpers for the b03 grant tracker.
package b03_tracker_pkg;

  localparam int N_CLIENTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    FAULT = 2'd2
  } tracker_state_t;

  typedef logic [1:0] client_idx_t;

  // Index of the highest set bit; only meaningful for a one-hot vector.
  function automatic client_idx_t onehot_to_idx(input logic [N_CLIENTS-1:0] vec);
    client_idx_t idx;
    idx = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (vec[i]) idx = client_idx_t'(i);
    end
    return idx;
  endfunction

  // True when two or more bits are set.
  function automatic logic is_multihot(input logic [N_CLIENTS-1:0] vec);
    logic [N_CLIENTS-1:0] one;
    one = {{(N_CLIENTS-1){1'b0}}, 1'b1};
    return (vec & (vec - one)) != '0;
  endfunction

endpackage

// File: rtl/b03_wait_counter.sv
// Per-client wait counter with registered starvation flag.
module b03_wait_counter
  import b03_tracker_pkg::*;
#(
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic request,
  input  logic grant,
  input  logic mask,
  output logic starve
);

  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;
  localparam logic [WAIT_W-1:0] LIMIT    = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q;

  // Count waiting cycles (saturating); flag starvation one edge after reaching the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
      starve <= 1'b0;
    end else begin
      starve <= (wait_q >= LIMIT);
      if (request && !grant && !mask) begin
        if (wait_q != '1) wait_q <= wait_q + WAIT_ONE;
      end else begin
        wait_q <= '0;
      end
    end
  end

endmodule

// File: rtl/b03_grant_tracker.sv
// Monitor for the b03 arbiter: ownership, tenure, grant counts, overrun masking,
// starvation and multi-hot grant faults.
module b03_grant_tracker
  import b03_tracker_pkg::*;
#(
  parameter int TENURE_W     = 8,
  parameter int MAX_TENURE   = 200,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [3:0]           grant_i,
  input  logic [3:0]           request_i,
  input  logic                 clear_i,
  input  logic [1:0]           cnt_sel_i,
  output logic                 owner_valid_o,
  output logic [1:0]           owner_o,
  output logic [TENURE_W-1:0]  tenure_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [3:0]           overrun_o,
  output logic [3:0]           mask_o,
  output logic [3:0]           starve_o,
  output logic                 fault_o
);

  localparam logic [TENURE_W-1:0] TEN_ONE = 1;
  localparam logic [TENURE_W-1:0] TEN_MAX = TENURE_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0]    CNT_ONE = 1;

  tracker_state_t       state_q, state_d;
  client_idx_t          owner_q, owner_d;
  logic [TENURE_W-1:0]  tenure_q, tenure_d;
  logic [CNT_W-1:0]     cnt_q [N_CLIENTS];
  logic [3:0]           overrun_q, overrun_d;
  logic [3:0]           mask_q, mask_d;
  logic [3:0]           ovr_set;
  logic                 inc_en;
  logic                 multihot;
  logic                 any_grant;
  client_idx_t          gidx;

  assign multihot  = is_multihot(grant_i);
  assign any_grant = |grant_i;
  assign gidx      = onehot_to_idx(grant_i);

  // State, owner and tenure registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      tenure_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tenure_q <= tenure_d;
    end
  end

  // Next-state decode; a multi-hot sample overrides everything, clear included.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tenure_d = tenure_q;
    inc_en   = 1'b0;
    ovr_set  = '0;
    if (multihot) begin
      state_d  = FAULT;
      tenure_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_grant) begin
            state_d  = OWNED;
            owner_d  = gidx;
            tenure_d = TEN_ONE;
            inc_en   = 1'b1;
          end
        end
        OWNED: begin
          if (!any_grant) begin
            state_d  = IDLE;
            tenure_d = '0;
          end else if (gidx == owner_q) begin
            if (tenure_q != '1) tenure_d = tenure_q + TEN_ONE;
            if (tenure_q == TEN_MAX) ovr_set[owner_q] = 1'b1;
          end else begin
            owner_d  = gidx;
            tenure_d = TEN_ONE;
            inc_en   = 1'b1;
          end
        end
        FAULT: begin
          if (clear_i) begin
            state_d  = IDLE;
            tenure_d = '0;
          end
        end
        default: begin
          state_d  = IDLE;
          tenure_d = '0;
        end
      endcase
    end
  end

  // Overrun is sticky; a mask bit releases once its request is seen low, and a fresh overrun wins.
  always_comb begin
    overrun_d = overrun_q | ovr_set;
    mask_d    = (mask_q & request_i) | ovr_set;
    if (clear_i) begin
      overrun_d = '0;
      mask_d    = '0;
    end
  end

  // Overrun and mask registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= '0;
      mask_q    <= '0;
    end else begin
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
    end
  end

  // Saturating per-client grant counters; the increment targets the one-hot grant bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (clear_i) begin
          cnt_q[i] <= '0;
        end else if (inc_en && grant_i[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_wait
    b03_wait_counter #(
      .WAIT_W       (TENURE_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wait (
      .clock   (clock),
      .reset_n (reset_n),
      .request (request_i[g]),
      .grant   (grant_i[g]),
      .mask    (mask_q[g]),
      .starve  (starve_o[g])
    );
  end

  assign owner_valid_o = (state_q == OWNED);
  assign fault_o       = (state_q == FAULT);
  assign owner_o       = owner_q;
  assign tenure_o      = tenure_q;
  assign overrun_o     = overrun_q;
  assign mask_o        = mask_q;
  assign cnt_o         = cnt_q[cnt_sel_i];

endmodule

// File: tb/tb_b03_grant_tracker.sv
// Testbench for b03_grant_tracker: directed scenarios plus a randomized run
// against a cycle-level reference model.
module tb_b03_grant_tracker;

  localparam int TW   = 8;
  localparam int MAXT = 4;
  localparam int SL   = 6;
  localparam int CW   = 16;
  localparam int TMAX = (1 << TW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset_n;
  logic [3:0]    grant_i;
  logic [3:0]    request_i;
  logic          clear_i;
  logic [1:0]    cnt_sel_i;
  logic          owner_valid_o;
  logic [1:0]    owner_o;
  logic [TW-1:0] tenure_o;
  logic [CW-1:0] cnt_o;
  logic [3:0]    overrun_o;
  logic [3:0]    mask_o;
  logic [3:0]    starve_o;
  logic          fault_o;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic       m_valid;
  logic [1:0] m_owner;
  int         m_tenure;
  int         m_cnt [4];
  int         m_wait [4];
  logic [3:0] m_over, m_mask, m_starve;
  logic       m_fault;

  b03_grant_tracker #(
    .TENURE_W     (TW),
    .MAX_TENURE   (MAXT),
    .STARVE_LIMIT (SL),
    .CNT_W        (CW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .grant_i       (grant_i),
    .request_i     (request_i),
    .clear_i       (clear_i),
    .cnt_sel_i     (cnt_sel_i),
    .owner_valid_o (owner_valid_o),
    .owner_o       (owner_o),
    .tenure_o      (tenure_o),
    .cnt_o         (cnt_o),
    .overrun_o     (overrun_o),
    .mask_o        (mask_o),
    .starve_o      (starve_o),
    .fault_o       (fault_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_valid = 1'b0; m_owner = 2'd0; m_tenure = 0; m_fault = 1'b0;
    m_over = '0; m_mask = '0; m_starve = '0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_wait[i] = 0; end
  endtask

  // One sampled cycle of the tracker rules, written in terms of ownership events.
  task automatic model_step(input logic [3:0] g, input logic [3:0] r, input logic clr);
    int pop;
    logic [1:0] idx;
    logic [3:0] set_v;
    pop = $countones(g);
    idx = 2'd0;
    set_v = '0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
    for (int i = 0; i < 4; i++) begin
      m_starve[i] = (m_wait[i] >= SL);
      if (r[i] && !g[i] && !m_mask[i]) m_wait[i] = (m_wait[i] < TMAX) ? m_wait[i] + 1 : TMAX;
      else m_wait[i] = 0;
    end
    if (pop > 1) begin
      m_fault = 1'b1; m_valid = 1'b0; m_tenure = 0;
    end else if (m_fault) begin
      if (clr) m_fault = 1'b0;
    end else if (pop == 1) begin
      if (m_valid && idx == m_owner) begin
        if (m_tenure < TMAX) m_tenure = m_tenure + 1;
        if (m_tenure == MAXT + 1) set_v[idx] = 1'b1;
      end else begin
        m_valid = 1'b1; m_owner = idx; m_tenure = 1;
        if (m_cnt[idx] < CMAX) m_cnt[idx] = m_cnt[idx] + 1;
      end
    end else begin
      m_valid = 1'b0; m_tenure = 0;
    end
    if (clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_over = '0; m_mask = '0;
    end else begin
      m_mask = (m_mask & r) | set_v;
      m_over = m_over | set_v;
    end
  endtask

  task automatic drive(input logic [3:0] g, input logic [3:0] r, input logic clr);
    grant_i = g; request_i = r; clear_i = clr;
    @(posedge clock);
    model_step(g, r, clr);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; grant_i = '0; request_i = '0; clear_i = 1'b0; cnt_sel_i = 2'd0;
    model_reset();
    #12;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({owner_valid_o, owner_o, tenure_o, overrun_o, mask_o, starve_o, fault_o, cnt_o} !== '0) begin
      $display("FAIL reset_state: got valid=%b owner=%0d tenure=%0d ovr=%b mask=%b starve=%b fault=%b cnt=%0d, expected all 0",
               owner_valid_o, owner_o, tenure_o, overrun_o, mask_o, starve_o, fault_o, cnt_o);
    end else passed++;
  endtask

  task automatic test_tenure();
    for (int k = 1; k <= 3; k++) begin
      drive(4'b0001, 4'b0000, 1'b0);
      checks++;
      if (owner_valid_o !== 1'b1 || owner_o !== 2'd0 || tenure_o !== TW'(k)) begin
        $display("FAIL tenure_step%0d: got valid=%b owner=%0d tenure=%0d, expected 1/0/%0d",
                 k, owner_valid_o, owner_o, tenure_o, k);
      end else passed++;
    end
    drive(4'b0000, 4'b0000, 1'b0);
    cnt_sel_i = 2'd0;
    #1;
    checks++;
    if (owner_valid_o !== 1'b0 || tenure_o !== '0 || cnt_o !== CW'(1) || overrun_o !== 4'b0000) begin
      $display("FAIL tenure_release: got valid=%b tenure=%0d cnt=%0d ovr=%b, expected 0/0/1/0000",
               owner_valid_o, tenure_o, cnt_o, overrun_o);
    end else passed++;
  endtask

  task automatic test_overrun();
    for (int k = 1; k <= 6; k++) begin
      drive(4'b0100, 4'b0100, 1'b0);
      if (k == 4) begin
        checks++;
        if (overrun_o !== 4'b0000 || mask_o !== 4'b0000) begin
          $display("FAIL overrun_early: got ovr=%b mask=%b, expected 0000/0000", overrun_o, mask_o);
        end else passed++;
      end
      if (k == 5) begin
        checks++;
        if (overrun_o !== 4'b0100 || mask_o !== 4'b0100 || tenure_o !== TW'(5)) begin
          $display("FAIL overrun_rise: got ovr=%b mask=%b tenure=%0d, expected 0100/0100/5",
                   overrun_o, mask_o, tenure_o);
        end else passed++;
      end
    end
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (mask_o !== 4'b0000 || overrun_o !== 4'b0100) begin
      $display("FAIL mask_release: got mask=%b ovr=%b, expected 0000/0100", mask_o, overrun_o);
    end else passed++;
    drive(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (overrun_o !== 4'b0000) begin
      $display("FAIL overrun_clear: got ovr=%b, expected 0000", overrun_o);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    drive(4'b0010, 4'b0000, 1'b0);
    checks++;
    if (owner_o !== 2'd1 || tenure_o !== TW'(1) || owner_valid_o !== 1'b1) begin
      $display("FAIL handoff_first: got owner=%0d tenure=%0d valid=%b, expected 1/1/1", owner_o, tenure_o, owner_valid_o);
    end else passed++;
    drive(4'b1000, 4'b0000, 1'b0);
    checks++;
    if (owner_o !== 2'd3 || tenure_o !== TW'(1) || owner_valid_o !== 1'b1) begin
      $display("FAIL handoff_second: got owner=%0d tenure=%0d valid=%b, expected 3/1/1", owner_o, tenure_o, owner_valid_o);
    end else passed++;
    drive(4'b0000, 4'b0000, 1'b0);
    cnt_sel_i = 2'd1;
    #1;
    checks++;
    if (cnt_o !== CW'(1)) begin
      $display("FAIL handoff_cnt1: got %0d, expected 1", cnt_o);
    end else passed++;
    cnt_sel_i = 2'd3;
    #1;
    checks++;
    if (cnt_o !== CW'(1)) begin
      $display("FAIL handoff_cnt3: got %0d, expected 1", cnt_o);
    end else passed++;
  endtask

  task automatic test_fault();
    drive(4'b0011, 4'b0000, 1'b0);
    checks++;
    if (fault_o !== 1'b1 || owner_valid_o !== 1'b0) begin
      $display("FAIL fault_enter: got fault=%b valid=%b, expected 1/0", fault_o, owner_valid_o);
    end else passed++;
    drive(4'b0011, 4'b0000, 1'b1);
    checks++;
    if (fault_o !== 1'b1) begin
      $display("FAIL fault_clear_multihot: got fault=%b, expected 1", fault_o);
    end else passed++;
    drive(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (fault_o !== 1'b0 || owner_valid_o !== 1'b0) begin
      $display("FAIL fault_exit: got fault=%b valid=%b, expected 0/0", fault_o, owner_valid_o);
    end else passed++;
    drive(4'b0001, 4'b0000, 1'b0);
    checks++;
    if (owner_valid_o !== 1'b1 || tenure_o !== TW'(1)) begin
      $display("FAIL fault_recover: got valid=%b tenure=%0d, expected 1/1", owner_valid_o, tenure_o);
    end else passed++;
  endtask

  task automatic test_starve();
    drive(4'b0000, 4'b0000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      drive(4'b0000, 4'b0001, 1'b0);
      if (k == 6) begin
        checks++;
        if (starve_o !== 4'b0000) begin
          $display("FAIL starve_early: got %b, expected 0000", starve_o);
        end else passed++;
      end
    end
    checks++;
    if (starve_o !== 4'b0001) begin
      $display("FAIL starve_rise: got %b, expected 0001", starve_o);
    end else passed++;
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0);
    checks++;
    if (starve_o !== 4'b0000) begin
      $display("FAIL starve_drop: got %b, expected 0000", starve_o);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    drive(4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0000, 1'b0);
    checks++;
    if (tenure_o !== TW'(3)) begin
      $display("FAIL reset_mid_pre: got tenure=%0d, expected 3", tenure_o);
    end else passed++;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (owner_valid_o !== 1'b0 || tenure_o !== '0) begin
      $display("FAIL reset_async: got valid=%b tenure=%0d, expected 0/0", owner_valid_o, tenure_o);
    end else passed++;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cnt_sel_i = 2'd0;
    #1;
    checks++;
    if ({owner_valid_o, owner_o, tenure_o, overrun_o, mask_o, starve_o, fault_o, cnt_o} !== '0) begin
      $display("FAIL reset_mid_state: got valid=%b owner=%0d tenure=%0d ovr=%b mask=%b starve=%b fault=%b cnt=%0d, expected all 0",
               owner_valid_o, owner_o, tenure_o, overrun_o, mask_o, starve_o, fault_o, cnt_o);
    end else passed++;
    drive(4'b0001, 4'b0000, 1'b0);
    checks++;
    if (tenure_o !== TW'(1) || owner_valid_o !== 1'b1) begin
      $display("FAIL reset_mid_fresh: got tenure=%0d valid=%b, expected 1/1", tenure_o, owner_valid_o);
    end else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  g, r, flip;
    logic        clr;
    logic [39:0] got, exp;
    int          roll;
    g = '0;
    r = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      roll = int'($urandom_range(0, 99));
      if (roll < 60)      g = g;
      else if (roll < 72) g = 4'b0000;
      else if (roll < 95) g = 4'b0001 << $urandom_range(0, 3);
      else                g = (4'b0011 << $urandom_range(0, 2)) | 4'(1 << $urandom_range(0, 3));
      flip = '0;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 7) == 0);
      r = r ^ flip;
      clr = ($urandom_range(0, 99) < 3);
      drive(g, r, clr);
      cnt_sel_i = 2'($urandom_range(0, 3));
      #1;
      got = {owner_valid_o, owner_o, tenure_o, overrun_o, mask_o, starve_o, fault_o, cnt_o};
      exp = {m_valid, m_owner, 8'(m_tenure), m_over, m_mask, m_starve, m_fault, 16'(m_cnt[cnt_sel_i])};
      checks++;
      if (got !== exp) begin
        $display("FAIL random_cycle%0d: got %h expected %h (valid,owner,tenure,ovr,mask,starve,fault,cnt; g=%b r=%b clr=%b sel=%0d)",
                 n, got, exp, g, r, clr, cnt_sel_i);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_tenure();
    test_overrun();
    test_back_to_back();
    test_fault();
    test_starve();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
